// File: rtl/div_shift_sub.sv
// Restoring shift-subtract divider: 2*size-bit dividend / size-bit divisor, one quotient bit per clock.
// Optional feature: define DIV_ZERO_DET_EN to short-cut divide-by-zero straight to DONE and raise div0.
module div_shift_sub #(
    parameter int size = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2*size:1]   dividend,
    input  logic [size:1]     divisor,
    output logic [2*size:1]   quotient,
    output logic [size:1]     remainder,
    output logic              busy,
    output logic              done,
    output logic              div0
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam int CW = $clog2(2*size) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(2*size - 1);

    state_t             state_q, state_d;
    logic [2*size:1]    shreg_q, shreg_d;
    logic [size:1]      dvs_q, dvs_d;
    logic [size:1]      prem_q, prem_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*size:1]    quotient_q, quotient_d;
    logic [size:1]      remainder_q, remainder_d;
    logic [size+1:1]    prem_shift;
    logic [size:1]      prem_sub;
    logic               prem_ge;
    logic               last_step;

    // After a subtraction the partial remainder is below the divisor, so only its low
    // size bits are ever stored; the shifted-in value is the full size+1-bit remainder.
    assign prem_shift = {prem_q, shreg_q[2*size]};
    assign prem_ge    = prem_shift >= {1'b0, dvs_q};
    assign prem_sub   = prem_shift[size:1] - dvs_q;
    assign last_step  = (cnt_q == LAST_STEP);

`ifdef DIV_ZERO_DET_EN
    logic div0_q, div0_d;
    logic divisor_zero;
    assign divisor_zero = (divisor == '0);
    assign div0         = div0_q;
`else
    assign div0 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_DET_EN
                    state_d = divisor_zero ? DONE : RUN;
`else
                    state_d = RUN;
`endif
                end
            end
            RUN:     if (last_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Quotient bits are shifted into the vacated low end of the dividend register.
    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        shreg_d     = shreg_q;
        dvs_d       = dvs_q;
        prem_d      = prem_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
`ifdef DIV_ZERO_DET_EN
        div0_d      = div0_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = dividend;
                    dvs_d   = divisor;
                    prem_d  = '0;
                    cnt_d   = '0;
`ifdef DIV_ZERO_DET_EN
                    div0_d  = divisor_zero;
                    if (divisor_zero) begin
                        quotient_d  = '1;
                        remainder_d = dividend[size:1];
                    end
`endif
                end
            end
            RUN: begin
                shreg_d = {shreg_q[2*size-1:1], prem_ge};
                prem_d  = prem_ge ? prem_sub : prem_shift[size:1];
                cnt_d   = cnt_q + 1'b1;
                if (last_step) begin
                    quotient_d  = {shreg_q[2*size-1:1], prem_ge};
                    remainder_d = prem_ge ? prem_sub : prem_shift[size:1];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q     <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef DIV_ZERO_DET_EN
            div0_q      <= 1'b0;
`endif
        end else begin
            shreg_q     <= shreg_d;
            dvs_q       <= dvs_d;
            prem_q      <= prem_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
`ifdef DIV_ZERO_DET_EN
            div0_q      <= div0_d;
`endif
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_div_shift_sub.sv
// Scoreboard bench for div_shift_sub (size = 8): stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_div_shift_sub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [16:1] dividend = '0;
    logic [8:1]  divisor = '0;
    logic [16:1] quotient;
    logic [8:1]  remainder;
    logic        busy;
    logic        done;
    logic        div0;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int txn_cnt  = 0;
    logic [24:0] sb_q[$];

`ifdef DIV_ZERO_DET_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
`endif

    div_shift_sub #(.size(8)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .busy(busy), .done(done), .div0(div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(1), 32'(0));
            end else begin
                logic [24:0] e;
                e = sb_q.pop_front();
                txn_cnt++;
                $display("txn %0d: q=0x%0h r=0x%0h div0=%0b (exp q=0x%0h r=0x%0h div0=%0b)",
                         txn_cnt, quotient, remainder, div0, e[24:9], e[8:1], e[0]);
                check("quotient", 32'(quotient), 32'(e[24:9]));
                check("remainder", 32'(remainder), 32'(e[8:1]));
                check("div0", 32'(div0), 32'(e[0]));
            end
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] eq, input logic [7:0] er, input bit ed0);
        int lat;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 16'hdead;
        divisor  = 8'h5a;
        sb_q.push_back({eq, er, ed0});
        check("busy_after_accept", 32'(busy), 32'(1));
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("done_latency", 32'(lat), (DZ && b == 8'd0) ? 32'(0) : 32'(16));
        @(posedge clk); #1;
        check("busy_after_done", 32'(busy), 32'(0));
        check("done_pulse_width", 32'(done), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen_low;
        logic [15:0] ra;
        logic [7:0]  rb;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_quotient", 32'(quotient), 32'(0));
        check("reset_remainder", 32'(remainder), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_div0", 32'(div0), 32'(0));

        run_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
        run_op(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0);
        run_op(16'd100, 8'd200, 16'd0, 8'd100, 1'b0);
        run_op(16'h1234, 8'd0, 16'hffff, 8'h34, DZ);
        run_op(16'd40, 8'd6, 16'd6, 8'd4, 1'b0);

        // Abort: reset five edges into RUN must cancel without a done pulse.
        @(negedge clk);
        dividend = 16'h1234;
        divisor  = 8'd5;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_quotient", 32'(quotient), 32'(0));
        check("abort_remainder", 32'(remainder), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        repeat (20) begin @(posedge clk); #1; end
        check("abort_idle_busy", 32'(busy), 32'(0));

        // Back-to-back with start held high; operands swapped right after the first accept.
        @(negedge clk);
        dividend = 16'd50;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        sb_q.push_back({16'd16, 8'd2, 1'b0});
        sb_q.push_back({16'd1, 8'd0, 1'b0});
        dividend = 16'd9;
        divisor  = 8'd9;
        n = 0;
        seen_low = 1'b0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (!busy) seen_low = 1'b1;
            else if (seen_low) break;
        end
        check("b2b_interval", 32'(n), 32'(18));
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        dividend = 16'd7;
        divisor  = 8'd2;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin @(posedge clk); #1; n++; end
        check("b2b_second_ends", 32'(busy), 32'(0));
        @(posedge clk); #1;
        check("run_pulse_ignored", 32'(busy), 32'(0));

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 8'($urandom_range(1, 255));
            run_op(ra, rb, ra / 16'(rb), 8'(ra % 16'(rb)), 1'b0);
        end

        repeat (4) @(posedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
